// File: rtl/varray_rle_writer.sv
// Run-length coalescing write stage for the virtual-array store: merges equal consecutive
// elements into runs of up to MAX_RUN and issues one store write per run. Define VARRAY_RLE_STATS_EN for run_count.
module varray_rle_writer #(
    parameter int VIRTUAL_ELEMENT_WIDTH = 4,
    parameter int VIRTUAL_ADDR_BITS     = 16,
    parameter int MAX_RUN               = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [VIRTUAL_ADDR_BITS-1:0]     start_addr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_data,
    input  logic                             in_last,
    output logic                             busy,
    output logic                             we,
    output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
    output logic [3:0]                       write_addr_len,
    output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
    output logic                             frame_done,
    output logic [VIRTUAL_ADDR_BITS-1:0]     elem_count
`ifdef VARRAY_RLE_STATS_EN
    ,
    output logic [VIRTUAL_ADDR_BITS-1:0]     run_count
`endif
);
    localparam logic [3:0] MAX_LEN = 4'(MAX_RUN);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
    state_t state;

    logic [VIRTUAL_ADDR_BITS-1:0]     run_start;
    logic [VIRTUAL_ELEMENT_WIDTH-1:0] run_data;
    logic [3:0]                       run_len;

    logic acc, brk, emit;
    // A run breaks on a value change or when it is already full; an empty run never breaks.
    assign acc  = (state == ACCUM) && in_valid && in_ready;
    assign brk  = (run_len != 4'd0) && ((in_data != run_data) || (run_len == MAX_LEN));
    assign emit = (state == FLUSH) || (acc && (brk || in_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            we             <= 1'b0;
            write_addr     <= '0;
            write_addr_len <= '0;
            dat_w          <= '0;
            frame_done     <= 1'b0;
            elem_count     <= '0;
            run_start      <= '0;
            run_data       <= '0;
            run_len        <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    run_start  <= start_addr;
                    run_len    <= 4'd0;
                    elem_count <= '0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b1;
                    state      <= ACCUM;
                end
                ACCUM: if (acc) begin
                    elem_count <= elem_count + 1'b1;
                    run_data   <= in_data;
                    if (brk) begin
                        we             <= 1'b1;
                        write_addr     <= run_start;
                        write_addr_len <= run_len;
                        dat_w          <= run_data;
                        run_start      <= run_start + VIRTUAL_ADDR_BITS'(run_len);
                        run_len        <= 4'd1;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                        end
                    end else begin
                        run_len <= run_len + 4'd1;
                        // Final element merges into the held run, so the write carries it directly.
                        if (in_last) begin
                            we             <= 1'b1;
                            write_addr     <= run_start;
                            write_addr_len <= run_len + 4'd1;
                            dat_w          <= in_data;
                            frame_done     <= 1'b1;
                            in_ready       <= 1'b0;
                            busy           <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    we             <= 1'b1;
                    write_addr     <= run_start;
                    write_addr_len <= run_len;
                    dat_w          <= run_data;
                    frame_done     <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VARRAY_RLE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            run_count <= '0;
        else if (state == IDLE && start)
            run_count <= '0;
        else if (emit)
            run_count <= run_count + 1'b1;
    end
`else
    logic unused_emit;
    assign unused_emit = emit;
`endif
endmodule

// File: tb/tb_varray_rle_writer.sv
// Directed bench for varray_rle_writer: captures every write and compares against hand-computed runs.
module tb_varray_rle_writer;
    localparam int EW = 4;
    localparam int AB = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AB-1:0] start_addr = '0;
    logic          in_valid = 1'b0;
    logic [EW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready, busy, we, frame_done;
    logic [AB-1:0] write_addr, elem_count;
    logic [3:0]    write_addr_len;
    logic [EW-1:0] dat_w;
`ifdef VARRAY_RLE_STATS_EN
    logic [AB-1:0] run_count;
`endif

    varray_rle_writer #(.VIRTUAL_ELEMENT_WIDTH(EW), .VIRTUAL_ADDR_BITS(AB), .MAX_RUN(15)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .busy(busy), .we(we), .write_addr(write_addr), .write_addr_len(write_addr_len),
        .dat_w(dat_w), .frame_done(frame_done), .elem_count(elem_count)
`ifdef VARRAY_RLE_STATS_EN
        , .run_count(run_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AB-1:0] a;
        logic [3:0]    l;
        logic [EW-1:0] d;
        logic          fd;
        int            c;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk) if (we) wq.push_back('{write_addr, write_addr_len, dat_w, frame_done, cyc});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_frame(input logic [AB-1:0] addr);
        @(negedge clk);
        wq.delete();
        start = 1'b1;
        start_addr = addr;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [EW-1:0] d, input logic last, input int gap);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("rdy_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic expect_wr(input string tag, input int i, input logic [AB-1:0] a,
                             input logic [3:0] l, input logic [EW-1:0] d, input logic fd);
        if (i < wq.size()) begin
            check({tag, "_addr"}, wq[i].a, a);
            check({tag, "_len"}, wq[i].l, l);
            check({tag, "_dat"}, wq[i].d, d);
            check({tag, "_fd"}, wq[i].fd, fd);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctl", {28'd0, in_ready, busy, we, frame_done}, 32'd0);
        check("rst_wr", {write_addr, write_addr_len, dat_w}, 32'd0);
        check("rst_cnt", elem_count, 32'd0);
        reset = 1'b0;

        // Break on the last element: old run, then flush of the single-element tail.
        begin_frame(16'd0);
        check("t1_ready", in_ready, 1);
        send(4'd12, 1'b0, 0);
        send(4'd12, 1'b0, 0);
        send(4'd6, 1'b1, 0);
        repeat (4) @(negedge clk);
        check("t1_nwr", wq.size(), 2);
        expect_wr("t1w0", 0, 16'd0, 4'd2, 4'd12, 1'b0);
        expect_wr("t1w1", 1, 16'd2, 4'd1, 4'd6, 1'b1);
        if (wq.size() == 2) check("t1_b2b", wq[1].c - wq[0].c, 1);
        check("t1_cnt", elem_count, 3);
        check("t1_idle", {busy, in_ready, we, frame_done}, 4'b0000);
`ifdef VARRAY_RLE_STATS_EN
        check("t1_runs", run_count, 2);
`endif

        // Whole frame is one run.
        begin_frame(16'd10);
        send(4'd6, 1'b0, 0);
        send(4'd6, 1'b0, 0);
        send(4'd6, 1'b1, 0);
        check("t2_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t2_nwr", wq.size(), 1);
        expect_wr("t2w0", 0, 16'd10, 4'd3, 4'd6, 1'b1);
        check("t2_cnt", elem_count, 3);

        // MAX_RUN cap splits a run of 17.
        begin_frame(16'd0);
        for (int i = 0; i < 17; i++) send(4'd5, i == 16, 0);
        repeat (3) @(negedge clk);
        check("t3_nwr", wq.size(), 2);
        expect_wr("t3w0", 0, 16'd0, 4'd15, 4'd5, 1'b0);
        expect_wr("t3w1", 1, 16'd15, 4'd2, 4'd5, 1'b1);
        check("t3_cnt", elem_count, 17);
`ifdef VARRAY_RLE_STATS_EN
        check("t3_runs", run_count, 2);
`endif

        // Idle input cycles do not break a run.
        begin_frame(16'd0);
        send(4'd7, 1'b0, 3);
        send(4'd7, 1'b0, 3);
        send(4'd7, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("t4_nwr", wq.size(), 1);
        expect_wr("t4w0", 0, 16'd0, 4'd3, 4'd7, 1'b1);

        // Run straddling the address wrap, with a start pulsed mid-frame.
        begin_frame(16'hFFFE);
        send(4'd9, 1'b0, 0);
        send(4'd9, 1'b0, 0);
        @(negedge clk);
        start = 1'b1;
        start_addr = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        send(4'd9, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("t5_nwr", wq.size(), 1);
        expect_wr("t5w0", 0, 16'hFFFE, 4'd3, 4'd9, 1'b1);
        begin_frame(16'd0);
        send(4'd1, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("t5b_nwr", wq.size(), 1);
        expect_wr("t5b", 0, 16'd0, 4'd1, 4'd1, 1'b1);

        // Reset mid-frame discards the held run.
        begin_frame(16'd0);
        send(4'd4, 1'b0, 0);
        send(4'd4, 1'b0, 0);
        check("t6_pre_cnt", elem_count, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t6_ctl", {28'd0, in_ready, busy, we, frame_done}, 32'd0);
        check("t6_wr", {write_addr, write_addr_len, dat_w}, 32'd0);
        check("t6_cnt", elem_count, 0);
`ifdef VARRAY_RLE_STATS_EN
        check("t6_runs", run_count, 0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_nowr", wq.size(), 0);
        begin_frame(16'h0020);
        send(4'd3, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("t6b_nwr", wq.size(), 1);
        expect_wr("t6b", 0, 16'h0020, 4'd1, 4'd3, 1'b1);
        check("t6b_cnt", elem_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
